id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised ID/EX pipeline stage register for the five-stage core, sitting between the decoder/regfile read (ID) and the ALU (EX). It carries the decoded instruction payload (`inst`, `inst_addr`, `op1`, `op2`, `rd_addr`, `reg_wen`) under a valid/ready handshake. The stage supports back-pressure stalls and synchronous flush on branch or jump redirect. An optional skid entry gives full throughput with a registered upstream ready.

## Interface
Parameters:
- `XLEN`, 32: operand, instruction and address width.
- `RADDR_W`, 5: destination register index width.
- `SKID`, 1: 1 selects a two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-low reset.
- `flush` input 1: kill all held beats (EX redirect).
- `in_valid` input 1: ID presents a beat.
- `in_ready` output 1: stage can accept a beat.
- `inst_i`, `inst_addr_i`, `op1_i`, `op2_i` input XLEN each: payload.
- `rd_addr_i` input RADDR_W: destination register.
- `reg_wen_i` input 1: register writeback enable.
- `out_valid` output 1: EX beat valid.
- `out_ready` input 1: EX accepts the beat.
- `inst_o`, `inst_addr_o`, `op1_o`, `op2_o`, `rd_addr_o`, `reg_wen_o` output: payload, with the same widths as the inputs.

## Operation
- A beat is accepted on a rising edge where `in_valid && in_ready`. It is delivered on a rising edge where `out_valid && out_ready`.
- Entries:
  - `main` drives the outputs.
  - `skid` (present only when SKID=1) holds a beat accepted while `main` is stalled.
- States for SKID=1:
  - EMPTY: main is empty and skid is empty.
  - BUSY: main is full and skid is empty.
  - FULL: main is full and skid is full.
- Transitions:
  - EMPTY to BUSY on accept.
  - BUSY stays BUSY on accept together with deliver (main reloads from input).
  - BUSY to EMPTY on deliver with no accept.
  - BUSY to FULL on accept with no deliver.
  - FULL to BUSY on deliver (main loads from skid). Accept is impossible in FULL.
- `in_ready` for SKID=1 is a flop equal to `!skid_valid`.
- For SKID=0 there is only EMPTY or BUSY, and `in_ready = !main_valid || out_ready`.
- When `out_valid` = 0, the outputs are forced as follows:
  - `inst_o` = 32'h0000_0013 (NOP, `addi x0,x0,0`).
  - `reg_wen_o` = 0.
  - All other payload outputs = 0.
- Flush:
  - On the edge where `flush` = 1, all entries are invalidated and the next state is EMPTY.
  - A beat presented in the same cycle is counted as consumed by ID but is discarded.
  - A delivery in the same cycle still completes, because EX sampled it.
- Reset has priority over flush, and flush has priority over handshakes.
- Payload is stored verbatim. There is no arithmetic and no width conversion.

## Timing
- Reset (`rst` low at an edge) sets the following on the next cycle:
  - `out_valid` = 0.
  - `in_ready` = 1.
  - NOP payload on the outputs.
  - Skid empty.
- Reset asserted mid-operation drops any held beats without delivering them.
- Latency: a beat accepted at edge N appears with `out_valid` = 1 after edge N.
- Throughput: one beat per cycle when `out_ready` stays high.
- With SKID=1, a one-cycle `out_ready` drop loses no beats and inserts no bubbles upstream until the skid entry is full.
- Payload outputs are stable while `out_valid && !out_ready`.
- With `flush` = 1 and FULL: next cycle is EMPTY and `in_ready` = 1.

## Structure
- Shared package `core_pkg`:
  - `NOP_INST` = 32'h0000_0013.
  - Default `XLEN` and `RADDR_W`.
  - Packed struct `idex_payload_t` holding `inst`, `inst_addr`, `op1`, `op2`, `rd_addr` and `reg_wen`.
- Sub-module `pipe_skid`: a generic payload-width skid register holding the valid/ready and state logic, parametrised by `W` and `SKID`.
- `id_ex_stage` packs and unpacks the payload struct, applies NOP forcing and wires `flush`.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `in_valid` = 1. Then `out_valid` = 0, `inst_o` = 32'h13, `reg_wen_o` = 0 and `in_ready` = 1.
- Streaming: 8 back-to-back beats with `inst_i` = 32'h00A0_0093 + k and `out_ready` = 1. The outputs appear 1 cycle later, in order, with no gaps.
- Stall, SKID=1:
  - Accept A then B while `out_ready` = 0. State is FULL and `in_ready` = 0.
  - Raise `out_ready`. A then B are delivered and `in_ready` returns to 1 one cycle after A is delivered.
- Stall, SKID=0: with `out_ready` = 0 after A, `in_ready` = 0 in the same cycle and the outputs hold A unchanged.
- Flush in FULL with a simultaneous `in_valid` (beat C): next cycle `out_valid` = 0, and C never appears on the outputs.
- Reset mid-FULL: assert `rst` = 0 while A and B are held. Neither is ever delivered, and after release the next accepted beat D is the first output.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default datapath widths, the NOP encoding and the
// ID/EX payload layout used by the pipeline registers.
package core_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_RADDR_W = 5;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [DEF_XLEN-1:0]    inst;
        logic [DEF_XLEN-1:0]    inst_addr;
        logic [DEF_XLEN-1:0]    op1;
        logic [DEF_XLEN-1:0]    op2;
        logic [DEF_RADDR_W-1:0] rd_addr;
        logic                   reg_wen;
    } idex_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid.sv
// Generic valid/ready pipeline register with an optional skid entry.
//   state    | meaning
//   ST_EMPTY | main empty, skid empty
//   ST_BUSY  | main full,  skid empty
//   ST_FULL  | main full,  skid full (only reachable with SKID=1)
module pipe_skid
    import core_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state, state_nxt;
    logic [W-1:0] main_q, skid_q;
    logic         accept, deliver;
    logic         load_main_in, load_main_skid, load_skid;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt    = ST_BUSY;
                    load_main_in = 1'b1;
                end
            end
            ST_BUSY: begin
                if (accept && deliver) begin
                    load_main_in = 1'b1;
                end else if (deliver) begin
                    state_nxt = ST_EMPTY;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    state_nxt      = ST_BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Data loads may still fire under flush; the entries are invalid anyway.
        if (flush) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_q <= in_data;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= in_data;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic rdy_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_nxt != ST_FULL);
                end
            end
            assign in_ready = rdy_q;
        end else begin : g_single
            assign in_ready = (state == ST_EMPTY) || out_ready;
        end
    endgenerate

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: packs the decoded payload through pipe_skid and
// presents a NOP with writeback disabled whenever no beat is valid.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter bit SKID    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    inst_i,
    input  logic [XLEN-1:0]    inst_addr_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               reg_wen_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    inst_o,
    output logic [XLEN-1:0]    inst_addr_o,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               reg_wen_o
);

    // Same field order as idex_payload_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]    inst;
        logic [XLEN-1:0]    inst_addr;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [RADDR_W-1:0] rd_addr;
        logic               reg_wen;
    } payload_t;

    payload_t in_p, out_p;

    assign in_p.inst      = inst_i;
    assign in_p.inst_addr = inst_addr_i;
    assign in_p.op1       = op1_i;
    assign in_p.op2       = op2_i;
    assign in_p.rd_addr   = rd_addr_i;
    assign in_p.reg_wen   = reg_wen_i;

    pipe_skid #(
        .W    ($bits(payload_t)),
        .SKID (SKID)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_p)
    );

    assign inst_o      = out_valid ? out_p.inst      : XLEN'(NOP_INST);
    assign inst_addr_o = out_valid ? out_p.inst_addr : '0;
    assign op1_o       = out_valid ? out_p.op1       : '0;
    assign op2_o       = out_valid ? out_p.op2       : '0;
    assign rd_addr_o   = out_valid ? out_p.rd_addr   : '0;
    assign reg_wen_o   = out_valid && out_p.reg_wen;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: one SKID=1 and one SKID=0 instance share
// the same stimulus; each has its own expected-beat queue and monitor.
module tb_id_ex_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst_val = 32'h0;
    idex_payload_t drv;

    logic        u1_in_ready, u1_out_valid, u1_reg_wen;
    logic [31:0] u1_inst, u1_addr, u1_op1, u1_op2;
    logic [4:0]  u1_rd;
    logic        u0_in_ready, u0_out_valid, u0_reg_wen;
    logic [31:0] u0_inst, u0_addr, u0_op1, u0_op2;
    logic [4:0]  u0_rd;

    idex_payload_t q1[$];
    idex_payload_t q0[$];
    int checks = 0;
    int failures = 0;
    int pops1 = 0;
    int pops0 = 0;

    always #5 clk = ~clk;

    function automatic idex_payload_t mk(input logic [31:0] ins);
        idex_payload_t p;
        p.inst      = ins;
        p.inst_addr = 32'h8000_0000 + {ins[29:0], 2'b00};
        p.op1       = ins ^ 32'h5A5A_5A5A;
        p.op2       = ~ins;
        p.rd_addr   = ins[11:7];
        p.reg_wen   = ins[0];
        return p;
    endfunction

    assign drv = mk(inst_val);

    id_ex_stage #(.XLEN(32), .RADDR_W(5), .SKID(1'b1)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(u1_in_ready),
        .inst_i(drv.inst), .inst_addr_i(drv.inst_addr), .op1_i(drv.op1), .op2_i(drv.op2),
        .rd_addr_i(drv.rd_addr), .reg_wen_i(drv.reg_wen),
        .out_valid(u1_out_valid), .out_ready(out_ready),
        .inst_o(u1_inst), .inst_addr_o(u1_addr), .op1_o(u1_op1), .op2_o(u1_op2),
        .rd_addr_o(u1_rd), .reg_wen_o(u1_reg_wen)
    );

    id_ex_stage #(.XLEN(32), .RADDR_W(5), .SKID(1'b0)) u0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(u0_in_ready),
        .inst_i(drv.inst), .inst_addr_i(drv.inst_addr), .op1_i(drv.op1), .op2_i(drv.op2),
        .rd_addr_i(drv.rd_addr), .reg_wen_i(drv.reg_wen),
        .out_valid(u0_out_valid), .out_ready(out_ready),
        .inst_o(u0_inst), .inst_addr_o(u0_addr), .op1_o(u0_op1), .op2_o(u0_op2),
        .rd_addr_o(u0_rd), .reg_wen_o(u0_reg_wen)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a beat is delivered at the coming edge when valid&&ready and reset is released.
    always @(negedge clk) begin
        idex_payload_t act, exp;
        if (rst && u1_out_valid && out_ready) begin
            act = '{u1_inst, u1_addr, u1_op1, u1_op2, u1_rd, u1_reg_wen};
            checks++;
            pops1++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL skid1_unexpected_beat actual=%h expected=none at %0t", act, $time);
            end else begin
                exp = q1.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL skid1_beat actual=%h expected=%h at %0t", act, exp, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        idex_payload_t act, exp;
        if (rst && u0_out_valid && out_ready) begin
            act = '{u0_inst, u0_addr, u0_op1, u0_op2, u0_rd, u0_reg_wen};
            checks++;
            pops0++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL skid0_unexpected_beat actual=%h expected=none at %0t", act, $time);
            end else begin
                exp = q0.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL skid0_beat actual=%h expected=%h at %0t", act, exp, $time);
                end
            end
        end
    end

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid  = v;
        inst_val  = ins;
        out_ready = ordy;
        flush     = fl;
        #3;
        if (rst && !fl && v && u1_in_ready) q1.push_back(mk(ins));
        if (rst && !fl && v && u0_in_ready) q0.push_back(mk(ins));
        @(posedge clk);
        #1;
        if (fl || !rst) begin
            q1.delete();
            q0.delete();
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held two cycles with a beat presented
        rst = 1'b0;
        step(1'b1, 32'hDEAD_0093, 1'b1, 1'b0);
        step(1'b1, 32'hDEAD_0093, 1'b1, 1'b0);
        chk("rst_u1_out_valid", {31'b0, u1_out_valid}, 32'd0);
        chk("rst_u1_inst", u1_inst, 32'h0000_0013);
        chk("rst_u1_reg_wen", {31'b0, u1_reg_wen}, 32'd0);
        chk("rst_u1_in_ready", {31'b0, u1_in_ready}, 32'd1);
        chk("rst_u1_op1", u1_op1, 32'd0);
        chk("rst_u0_out_valid", {31'b0, u0_out_valid}, 32'd0);
        chk("rst_u0_inst", u0_inst, 32'h0000_0013);
        chk("rst_u0_in_ready", {31'b0, u0_in_ready}, 32'd1);
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming: eight back-to-back beats, no gaps
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'h00A0_0093 + k, 1'b1, 1'b0);
            chk("stream_u1_valid", {31'b0, u1_out_valid}, 32'd1);
            chk("stream_u0_valid", {31'b0, u0_out_valid}, 32'd1);
            chk("stream_u1_inst", u1_inst, 32'h00A0_0093 + k);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_u1_valid", {31'b0, u1_out_valid}, 32'd0);
        chk("drain_u0_valid", {31'b0, u0_out_valid}, 32'd0);

        // Stall: A then B with EX not ready
        step(1'b1, 32'h0011_1113, 1'b0, 1'b0);
        chk("stall_u0_in_ready", {31'b0, u0_in_ready}, 32'd0);
        chk("stall_u0_inst_a", u0_inst, 32'h0011_1113);
        step(1'b1, 32'h0022_2213, 1'b0, 1'b0);
        chk("full_u1_in_ready", {31'b0, u1_in_ready}, 32'd0);
        chk("full_u1_inst_a", u1_inst, 32'h0011_1113);
        chk("hold_u0_inst_a", u0_inst, 32'h0011_1113);
        chk("hold_u0_op2_a", u0_op2, ~32'h0011_1113);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("unstall_u1_in_ready", {31'b0, u1_in_ready}, 32'd1);
        chk("unstall_u1_inst_b", u1_inst, 32'h0022_2213);
        chk("unstall_u0_valid", {31'b0, u0_out_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stall_drain_u1_valid", {31'b0, u1_out_valid}, 32'd0);

        // Flush in FULL with C presented and A2 being delivered
        step(1'b1, 32'h0033_3313, 1'b0, 1'b0);
        step(1'b1, 32'h0044_4413, 1'b0, 1'b0);
        step(1'b1, 32'h0CCC_C093, 1'b1, 1'b1);
        chk("flush_u1_valid", {31'b0, u1_out_valid}, 32'd0);
        chk("flush_u1_in_ready", {31'b0, u1_in_ready}, 32'd1);
        chk("flush_u1_inst", u1_inst, 32'h0000_0013);
        chk("flush_u0_valid", {31'b0, u0_out_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_flush_u1_valid", {31'b0, u1_out_valid}, 32'd0);
        chk("post_flush_u0_valid", {31'b0, u0_out_valid}, 32'd0);

        // Reset while FULL: held beats are dropped, D is the next output
        step(1'b1, 32'h0055_5513, 1'b0, 1'b0);
        step(1'b1, 32'h0066_6613, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        chk("midrst_u1_valid", {31'b0, u1_out_valid}, 32'd0);
        chk("midrst_u1_in_ready", {31'b0, u1_in_ready}, 32'd1);
        step(1'b1, 32'h0DDD_D093, 1'b1, 1'b0);
        chk("d_u1_inst", u1_inst, 32'h0DDD_D093);
        chk("d_u0_inst", u0_inst, 32'h0DDD_D093);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        chk("u1_pending", q1.size(), 32'd0);
        chk("u0_pending", q0.size(), 32'd0);
        chk("u1_delivered", pops1, 32'd12);
        chk("u0_delivered", pops0, 32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
